// File: rtl/attribute_scanner.sv
// attribute_scanner: walks HTML tags and feeds numeric attribute values to integer_parser.
// Optional macro ATTR_QUOTED_VALUES_EN accepts "..." quoted attribute values.
`timescale 1ns/1ps
module attribute_scanner #(
    parameter int CHAR_W = 8,
    parameter int VAL_W  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CHAR_W-1:0] int_char,
    output logic              int_enable,
    output logic              int_reset,
    input  logic              int_next_char,
    input  logic              int_has_finished,
    input  logic [VAL_W-1:0]  int_value,
    output logic              attr_valid,
    output logic [1:0]        attr_id,
    output logic [VAL_W-1:0]  attr_value,
    output logic              tag_done,
    output logic              bad_attr
);
    typedef enum logic [2:0] {
        S_IDLE, S_TAG, S_WAIT, S_NAME,
        S_VALUE, S_SKIP, S_EMIT, S_CLEAR
    } state_e;

    localparam logic [CHAR_W-1:0] C_LT = CHAR_W'(8'h3C);
    localparam logic [CHAR_W-1:0] C_GT = CHAR_W'(8'h3E);
    localparam logic [CHAR_W-1:0] C_SP = CHAR_W'(8'h20);
    localparam logic [CHAR_W-1:0] C_EQ = CHAR_W'(8'h3D);
    localparam logic [CHAR_W-1:0] C_QT = CHAR_W'(8'h22);

    state_e             state_q;
    logic [3:0]         flags_q;
    logic [2:0]         idx_q;
    logic [1:0]         cand_q;
    logic [CHAR_W-1:0]  term_q;
    logic               first_q;
    logic               attr_valid_q;
    logic               tag_done_q;
    logic               bad_attr_q;
    logic [1:0]         attr_id_q;
    logic [VAL_W-1:0]   attr_value_q;
`ifdef ATTR_QUOTED_VALUES_EN
    logic               quoted_q;
    logic               drop_q;
`endif

    // Names stored left-justified; positions past the end read as NUL.
    function automatic logic [7:0] name_char(input logic [1:0] id,
                                             input logic [2:0] idx);
        logic [63:0] s;
        case (id)
            2'd0:    s = {"left", 32'h0};
            2'd1:    s = {"top", 40'h0};
            2'd2:    s = {"width", 24'h0};
            default: s = {"height", 16'h0};
        endcase
        return s[6'd63 - {idx, 3'b000} -: 8];
    endfunction

    function automatic logic [2:0] name_len(input logic [1:0] id);
        case (id)
            2'd0:    return 3'd4;
            2'd1:    return 3'd3;
            2'd2:    return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    logic [3:0] hit_cur;
    logic [3:0] hit_first;
    logic [1:0] enc;
    logic       single;
    logic       is_sp;
    logic       is_gt;
    logic       is_eq;
    logic       quote_first;
    logic       rdy;
    logic       fire;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            hit_cur[k]   = CHAR_W'(name_char(2'(k), idx_q)) == in_char;
            hit_first[k] = CHAR_W'(name_char(2'(k), 3'd0)) == in_char;
        end
    end

    always_comb begin
        enc = 2'd0;
        if (flags_q[3])      enc = 2'd3;
        else if (flags_q[2]) enc = 2'd2;
        else if (flags_q[1]) enc = 2'd1;
    end

    assign single      = (|flags_q) && ((flags_q & (flags_q - 4'd1)) == 4'd0);
    assign is_sp       = in_char == C_SP;
    assign is_gt       = in_char == C_GT;
    assign is_eq       = in_char == C_EQ;
    assign quote_first = first_q && (in_char == C_QT);

    always_comb begin
        rdy = 1'b0;
        case (state_q)
            S_IDLE, S_TAG, S_WAIT, S_NAME, S_SKIP: rdy = 1'b1;
            S_VALUE: begin
                rdy = int_next_char;
`ifdef ATTR_QUOTED_VALUES_EN
                if (quote_first && !int_has_finished) rdy = 1'b1;
`endif
            end
            default: rdy = 1'b0;
        endcase
    end

    assign fire       = in_valid && rdy;
    assign in_ready   = reset && rdy;
    assign int_enable = (state_q == S_VALUE) && in_valid && !quote_first;
    assign int_reset  = state_q == S_CLEAR;

    // A closing quote is shown to the parser as a space so it terminates.
    always_comb begin
        int_char = '0;
        if (int_enable) begin
            int_char = in_char;
`ifdef ATTR_QUOTED_VALUES_EN
            if (quoted_q && in_char == C_QT) int_char = C_SP;
`endif
        end
    end

    assign attr_valid = attr_valid_q;
    assign attr_id    = attr_id_q;
    assign attr_value = attr_value_q;
    assign tag_done   = tag_done_q;
    assign bad_attr   = bad_attr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            flags_q      <= 4'hF;
            idx_q        <= 3'd0;
            cand_q       <= 2'd0;
            term_q       <= '0;
            first_q      <= 1'b0;
            attr_valid_q <= 1'b0;
            tag_done_q   <= 1'b0;
            bad_attr_q   <= 1'b0;
            attr_id_q    <= 2'd0;
            attr_value_q <= '0;
`ifdef ATTR_QUOTED_VALUES_EN
            quoted_q     <= 1'b0;
            drop_q       <= 1'b0;
`endif
        end else begin
            attr_valid_q <= 1'b0;
            tag_done_q   <= 1'b0;
            bad_attr_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fire && in_char == C_LT) state_q <= S_TAG;
                end
                S_TAG: begin
                    if (fire && is_sp) begin
                        state_q <= S_WAIT;
                    end else if (fire && is_gt) begin
                        tag_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (fire) begin
`ifdef ATTR_QUOTED_VALUES_EN
                        drop_q <= 1'b0;
                        if (!drop_q)
`endif
                        begin
                            if (is_gt) begin
                                tag_done_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else if (!is_sp) begin
                                flags_q <= hit_first;
                                idx_q   <= 3'd1;
                                state_q <= S_NAME;
                            end
                        end
                    end
                end
                S_NAME: begin
                    if (fire && is_eq) begin
                        if (single && idx_q == name_len(enc)) begin
                            cand_q  <= enc;
                            first_q <= 1'b1;
                            state_q <= S_VALUE;
`ifdef ATTR_QUOTED_VALUES_EN
                            quoted_q <= 1'b0;
`endif
                        end else begin
                            state_q <= S_SKIP;
                        end
                    end else if (fire && (is_sp || is_gt)) begin
                        bad_attr_q <= |flags_q;
                        tag_done_q <= is_gt;
                        state_q    <= is_gt ? S_IDLE : S_WAIT;
                    end else if (fire) begin
                        flags_q <= flags_q & hit_cur;
                        if (idx_q != 3'd7) idx_q <= idx_q + 3'd1;
                    end
                end
                S_VALUE: begin
                    // Terminator stays on the bus; the next state pops it.
                    if (int_has_finished && in_valid) begin
                        term_q       <= in_char;
                        attr_valid_q <= 1'b1;
                        attr_id_q    <= cand_q;
                        attr_value_q <= int_value;
                        state_q      <= S_EMIT;
                    end else if (in_valid && quote_first) begin
`ifdef ATTR_QUOTED_VALUES_EN
                        quoted_q <= 1'b1;
                        first_q  <= 1'b0;
`else
                        bad_attr_q <= 1'b1;
                        state_q    <= S_SKIP;
`endif
                    end else if (fire) begin
                        first_q <= 1'b0;
                    end
                end
                S_EMIT: state_q <= S_CLEAR;
                S_CLEAR: begin
                    if (term_q == C_GT) begin
                        tag_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else if (term_q == C_SP) begin
                        state_q <= S_WAIT;
`ifdef ATTR_QUOTED_VALUES_EN
                    end else if (term_q == C_QT) begin
                        drop_q  <= 1'b1;
                        state_q <= S_WAIT;
`endif
                    end else begin
                        state_q <= S_SKIP;
                    end
                end
                S_SKIP: begin
                    if (fire && is_sp) begin
                        state_q <= S_WAIT;
                    end else if (fire && is_gt) begin
                        tag_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_attribute_scanner.sv
// Testbench for attribute_scanner with a behavioural integer_parser
// and an (id, value) scoreboard.
`timescale 1ns/1ps
module tb_attribute_scanner;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_char = 8'h0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] int_char;
    logic       int_enable;
    logic       int_reset;
    logic       int_next_char;
    logic       int_has_finished;
    logic [9:0] int_value;
    logic       attr_valid;
    logic [1:0] attr_id;
    logic [9:0] attr_value;
    logic       tag_done;
    logic       bad_attr;

    always #5 clock = ~clock;

    attribute_scanner #(.CHAR_W(8), .VAL_W(10)) dut (
        .clock(clock), .reset(reset),
        .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
        .int_char(int_char), .int_enable(int_enable), .int_reset(int_reset),
        .int_next_char(int_next_char), .int_has_finished(int_has_finished),
        .int_value(int_value),
        .attr_valid(attr_valid), .attr_id(attr_id), .attr_value(attr_value),
        .tag_done(tag_done), .bad_attr(bad_attr)
    );

    // Behavioural integer_parser: digits accumulate, anything else ends the number.
    logic [9:0] pval;
    logic       pfin;

    function automatic logic is_dig(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    assign int_next_char    = int_enable && !pfin && is_dig(int_char);
    assign int_has_finished = pfin;
    assign int_value        = pval;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pval <= 10'd0;
            pfin <= 1'b0;
        end else if (int_reset) begin
            pval <= 10'd0;
            pfin <= 1'b0;
        end else if (int_enable && !pfin) begin
            if (is_dig(int_char)) pval <= 10'(pval * 10 + 10'(int_char - 8'h30));
            else pfin <= 1'b1;
        end
    end

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   errors = 0;
    int   checks = 0;
    int   tag_cnt = 0;
    int   bad_cnt = 0;
    int   val_cnt = 0;
    int   cyc = 0;
    int   last_clr = -100;
    int   last_tag = -200;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (attr_valid) begin
                val_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_attr got id=%0d value=%0d want none",
                             attr_id, attr_value);
                end else begin
                    m_e = sb.pop_front();
                    if (attr_id !== m_e.id || attr_value !== m_e.v) begin
                        errors++;
                        $display("FAIL attr_pair got (%0d,%0d) want (%0d,%0d)",
                                 attr_id, attr_value, m_e.id, m_e.v);
                    end
                end
            end
            if (attr_valid || int_reset) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_emit_clear got %0b want 0", in_ready);
                end
            end
            if (attr_valid || tag_done) begin
                checks++;
                if (attr_valid && tag_done) begin
                    errors++;
                    $display("FAIL pulse_overlap got both want exclusive");
                end
            end
            if (int_reset) last_clr = cyc;
            if (tag_done) begin
                tag_cnt++;
                last_tag = cyc;
            end
            if (bad_attr) bad_cnt++;
        end
    end

    task automatic send_char(input logic [7:0] c, input bit gap);
        int n;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        in_char  = c;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            n++;
            if (n > 40) begin
                errors++;
                checks++;
                $display("FAIL stall char=%0h got no in_ready want handshake", c);
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input bit tog);
        for (int i = 0; i < s.len(); i++) send_char(s[i], tog);
        in_valid = 1'b0;
    endtask

    task automatic start_test();
        tag_cnt = 0;
        bad_cnt = 0;
        val_cnt = 0;
    endtask

    task automatic finish_test(input string name, input int nv,
                               input int nt, input int nb);
        repeat (8) @(posedge clock);
        #1;
        checks++;
        if (val_cnt !== nv || sb.size() !== 0) begin
            errors++;
            $display("FAIL %s_attr_count got %0d (left %0d) want %0d",
                     name, val_cnt, sb.size(), nv);
            sb.delete();
        end
        checks++;
        if (tag_cnt !== nt) begin
            errors++;
            $display("FAIL %s_tag_done got %0d want %0d", name, tag_cnt, nt);
        end
        checks++;
        if (bad_cnt !== nb) begin
            errors++;
            $display("FAIL %s_bad_attr got %0d want %0d", name, bad_cnt, nb);
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_char  = 8'h3C;
        #2 reset = 1'b0;
        #10;
        checks++;
        if ({in_ready, int_enable, int_reset, attr_valid, tag_done, bad_attr} !== 6'b0 ||
            int_char !== 8'h0 || attr_id !== 2'd0 || attr_value !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b en=%0b clr=%0b av=%0b td=%0b ba=%0b want all 0",
                     in_ready, int_enable, int_reset, attr_valid, tag_done, bad_attr);
        end
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        start_test();
        sb.push_back('{2'd2, 10'd120});
        send_str("<div width=120>", 1'b0);
        finish_test("single", 1, 1, 0);
        checks++;
        if (last_tag - last_clr !== 1) begin
            errors++;
            $display("FAIL tag_after_clear got %0d cycles want 1", last_tag - last_clr);
        end
    endtask

    task automatic test_multi();
        start_test();
        sb.push_back('{2'd0, 10'd5});
        sb.push_back('{2'd1, 10'd37});
        sb.push_back('{2'd3, 10'd1023});
        send_str("<p left=5 top=37 height=1023>", 1'b0);
        finish_test("multi", 3, 1, 0);
    endtask

    task automatic test_skip();
        start_test();
        sb.push_back('{2'd2, 10'd9});
        send_str("<a href=77 wid=3 width=9>", 1'b0);
        finish_test("skip", 1, 1, 0);
    endtask

    task automatic test_toggle();
        start_test();
        sb.push_back('{2'd1, 10'd42});
        send_str("<q top=42 >", 1'b1);
        finish_test("toggle", 1, 1, 0);
    endtask

    task automatic test_bad_name();
        start_test();
        send_str("<p top wid>", 1'b0);
        finish_test("bad_name", 0, 1, 2);
    endtask

    task automatic test_overflow();
        start_test();
        sb.push_back('{2'd3, 10'd6});
        send_str("<s height=1030>", 1'b0);
        finish_test("overflow", 1, 1, 0);
    endtask

    task automatic test_back_to_back();
        start_test();
        sb.push_back('{2'd1, 10'd3});
        sb.push_back('{2'd0, 10'd7});
        send_str("<b top=3><c left=7>", 1'b0);
        finish_test("b2b", 2, 2, 0);
    endtask

    task automatic test_reset_mid();
        start_test();
        send_str("<x width=1", 1'b0);
        in_char  = 8'h32;
        in_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (int_enable !== 1'b1) begin
            errors++;
            $display("FAIL mid_value_enable got %0b want 1", int_enable);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, int_enable, int_reset, attr_valid, tag_done, bad_attr} !== 6'b0 ||
            int_char !== 8'h0 || attr_id !== 2'd0 || attr_value !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got rdy=%0b en=%0b id=%0d val=%0d want all 0",
                     in_ready, int_enable, attr_id, attr_value);
        end
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        start_test();
        sb.push_back('{2'd1, 10'd3});
        send_str("<b top=3>", 1'b0);
        finish_test("after_reset", 1, 1, 0);
    endtask

    task automatic test_quoted();
        start_test();
`ifdef ATTR_QUOTED_VALUES_EN
        sb.push_back('{2'd0, 10'd64});
        send_str("<i left=\"64\">", 1'b0);
        finish_test("quoted", 1, 1, 0);
`else
        send_str("<i left=\"64\">", 1'b0);
        finish_test("quoted", 0, 1, 1);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_skip();
        test_toggle();
        test_bad_name();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_quoted();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/attribute_scanner.md
Name: attribute_scanner

Overview:
- Upstream sequencer for integer_parser. Consumes the raw HTML character stream one tag at a time.
- Recognises a fixed set of numeric attribute names and hands each value's characters to integer_parser through that block's next_char / has_finished handshake.
- Emits (attr_id, value) pairs to the layout stage. Unknown attributes are skipped.

Parameters:
- CHAR_W, 8, character width; matches `CHAR_BITES.
- VAL_W, 10, attribute value width; matches `ATTRIBUTE_VAL_BITES.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_char  in  CHAR_W  current stream character
- in_valid  in  1  in_char is valid
- in_ready  out  1  character consumed this cycle (in_valid & in_ready)
- int_char  out  CHAR_W  character presented to integer_parser
- int_enable  out  1  integer_parser enable
- int_reset  out  1  integer_parser sync clear
- int_next_char  in  1  integer_parser consumed int_char
- int_has_finished  in  1  integer_parser saw terminator
- int_value  in  VAL_W  integer_parser result
- attr_valid  out  1  one-cycle pulse: attr_id/attr_value valid
- attr_id  out  2  0=left 1=top 2=width 3=height
- attr_value  out  VAL_W  parsed value
- tag_done  out  1  one-cycle pulse on the closing '>'
- bad_attr  out  1  one-cycle pulse when a recognised name is malformed

Behaviour:
- Reset (async, reset low): state=IDLE. All outputs 0. Name-match flags all set. Name index counter = 0.
- States: IDLE, TAG_NAME, WAIT_ATTR, ATTR_NAME, VALUE, SKIP, EMIT, CLEAR.
- in_ready=1 in IDLE, TAG_NAME, WAIT_ATTR, ATTR_NAME and SKIP. In VALUE, in_ready=int_next_char. In EMIT and CLEAR, in_ready=0.
- IDLE: on '<' go to TAG_NAME. Ignore all other characters.
- TAG_NAME: on ' ' go to WAIT_ATTR. On '>' pulse tag_done and go to IDLE.
- WAIT_ATTR: skip ' '. On '>' pulse tag_done and go to IDLE. On any other character: load the match flags, set index=1, go to ATTR_NAME.
- Name matching: 4 candidate names ("left", "top", "width", "height"), max length 6. Each consumed name character clears the flag of any candidate whose character at the current index differs. Index saturates at 7.
- ATTR_NAME, on '=':
  - exactly one flag set and index equals that name's length: latch attr_id, go to VALUE.
  - otherwise go to SKIP.
- ATTR_NAME, on ' ' or '>':
  - if any flag was still set, pulse bad_attr.
  - ' ' returns to WAIT_ATTR. '>' pulses tag_done and returns to IDLE.
- VALUE:
  - int_enable=1 and int_char=in_char whenever in_valid. int_enable is held at 0 while in_valid=0.
  - An input character is popped only in a cycle where int_next_char=1.
  - int_has_finished=1 latches the terminator (' ' or '>') without consuming it, then go to EMIT.
- EMIT (1 cycle): attr_value=int_value, attr_valid=1, int_enable=0.
- CLEAR (1 cycle): int_reset=1, int_enable=0. Then:
  - terminator ' ': pop it, go to WAIT_ATTR.
  - terminator '>': pop it, pulse tag_done, go to IDLE.
- SKIP: consume until ' ' (go to WAIT_ATTR) or '>' (tag_done, go to IDLE). Never enables integer_parser.
- Overflow: value wraps modulo 2^VAL_W. This is inherited from integer_parser and not flagged.
- attr_id and attr_value hold their values between pulses.
- tag_done and attr_valid never assert in the same cycle.
- A '<' seen in any state other than IDLE is treated as an ordinary character.
- Reset asserted mid-value: int_enable drops immediately. integer_parser clearing is then the top level's responsibility via its own reset.

Optional Feature:
- Macro: ATTR_QUOTED_VALUES_EN.
- Defined:
  - A '"' as the first value character is popped without being forwarded.
  - The closing '"' is presented to integer_parser as ' ' so the parser terminates. It is popped on EMIT → CLEAR.
  - The following real ' ' or '>' is handled in WAIT_ATTR.
- Undefined: a '"' as the first value character pulses bad_attr and the state goes to SKIP.

Test Plan:
- `<div width=120>` → one attr_valid with attr_id=2, attr_value=120; tag_done one cycle after CLEAR; no bad_attr.
- `<p left=5 top=37 height=1023>` → three attr_valid pulses in order (0,5), (1,37), (3,1023); one tag_done.
- `<a href=77 wid=3 width=9>` → href and wid are skipped with no output; one pulse (2,9); tag_done.
- in_valid toggling every other cycle during `top=42 ` → (1,42); no character dropped or duplicated; in_ready low in EMIT and CLEAR.
- Reset pulled low while in VALUE of `width=12` → all outputs 0 the same cycle, state IDLE; a subsequent `<b top=3>` yields (1,3).
- With ATTR_QUOTED_VALUES_EN, `<i left="64">` → (0,64) then tag_done. Without it → bad_attr, no attr_valid, tag_done.
